// File: rtl/scan_chain_driver.sv
// Scan chain master: serialises an N-bit word MSB-first onto scan_in while
// capturing the chain's previous contents from scan_out as a readback word.
module scan_chain_driver #(
  parameter int N = 32,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic         scan_clk,
  input  logic         scan_rstb,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [N-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [N-1:0] rd_data,
  output logic         scan_en,
  output logic         scan_in,
  input  logic         scan_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} state_t;

  state_t             state_reg, state_next;
  logic [N-1:0]       tx_reg, tx_next;
  logic [N-1:0]       cap_reg, cap_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               arm_reg, arm_next;
  logic               scan_en_reg, scan_en_next;
  logic               scan_in_reg, scan_in_next;
  logic               rd_valid_reg, rd_valid_next;
  logic [N-1:0]       rd_data_reg, rd_data_next;

  always_ff @(posedge scan_clk or negedge scan_rstb) begin
    if (!scan_rstb) begin
      state_reg    <= IDLE;
      tx_reg       <= '0;
      cap_reg      <= '0;
      cnt_reg      <= '0;
      arm_reg      <= 1'b0;
      scan_en_reg  <= 1'b0;
      scan_in_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      tx_reg       <= tx_next;
      cap_reg      <= cap_next;
      cnt_reg      <= cnt_next;
      arm_reg      <= arm_next;
      scan_en_reg  <= scan_en_next;
      scan_in_reg  <= scan_in_next;
      rd_valid_reg <= rd_valid_next;
      rd_data_reg  <= rd_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tx_next       = tx_reg;
    cap_next      = cap_reg;
    cnt_next      = cnt_reg;
    arm_next      = arm_reg;
    scan_en_next  = scan_en_reg;
    scan_in_next  = scan_in_reg;
    rd_valid_next = rd_valid_reg;
    rd_data_next  = rd_data_reg;

    case (state_reg)
      IDLE: begin
        if (wr_valid) begin
          tx_next      = wr_data;
          scan_in_next = wr_data[N-1];
          scan_en_next = 1'b1;
          cnt_next     = '0;
          arm_next     = 1'b0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        tx_next  = {tx_reg[N-2:0], 1'b0};
        // scan_out only carries chain data after the first shift edge
        arm_next = 1'b1;
        if (arm_reg) begin
          cap_next = {cap_reg[N-2:0], scan_out};
          cnt_next = cnt_reg + CNT_W'(1);
        end
        if (arm_reg && cnt_reg == CNT_W'(N - 2)) begin
          scan_en_next = 1'b0;
          scan_in_next = 1'b0;
          state_next   = CAPTURE;
        end else begin
          scan_in_next = tx_reg[N-2];
        end
      end
      CAPTURE: begin
        // chain is no longer shifting, so scan_out still holds the last bit
        cap_next      = {cap_reg[N-2:0], scan_out};
        rd_data_next  = {cap_reg[N-2:0], scan_out};
        rd_valid_next = 1'b1;
        if (cnt_reg != CNT_W'(N)) cnt_next = cnt_reg + CNT_W'(1);
        state_next    = RESP;
      end
      RESP: begin
        if (rd_ready) begin
          rd_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign scan_en  = scan_en_reg;
  assign scan_in  = scan_in_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Self-checking bench: drives scan_chain_driver against a behavioural scan chain
// and checks readback/dout against a word-level model of the chain contents.
module tb_scan_chain_driver;
  localparam int N = 8;

  logic         scan_clk = 1'b0;
  logic         scan_rstb = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [N-1:0] wr_data = '0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [N-1:0] rd_data;
  logic         scan_en;
  logic         scan_in;
  logic         scan_out;
  logic         busy;

  scan_chain_driver #(.N(N)) dut (
    .scan_clk (scan_clk),
    .scan_rstb(scan_rstb),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out),
    .busy     (busy)
  );

  always #5 scan_clk = ~scan_clk;

  // behavioural chain: shifts in at LSB, registered serial output from MSB
  logic [N-1:0] rst_din = 8'hA5;
  logic [N-1:0] chain_dout;
  logic         chain_so;
  int           en_cnt = 0;
  assign scan_out = chain_so;

  always @(posedge scan_clk or negedge scan_rstb) begin
    if (!scan_rstb) begin
      chain_dout <= rst_din;
      chain_so   <= 1'b0;
    end else if (scan_en) begin
      chain_so   <= chain_dout[N-1];
      chain_dout <= {chain_dout[N-2:0], scan_in};
      en_cnt     <= en_cnt + 1;
    end
  end

  int n_vec = 0;
  int n_miss = 0;
  logic [N-1:0] exp_chain;
  logic [N-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // one full write/readback transaction; hold = cycles of rd_ready low in RESP
  task automatic run_op(input logic [N-1:0] w, input int hold, input bit poke, input bit coincide);
    int lat;
    int en0;
    logic [N-1:0] exp_rd;
    exp_rd = exp_chain;
    exp_chain = w;
    check_val("pre_wr_ready", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data  = w;
    rd_ready = 1'b0;
    en0 = en_cnt;
    @(negedge scan_clk);
    wr_valid = 1'b0;
    wr_data  = N'($urandom);
    check_val("busy_shift", busy, 1);
    check_val("scan_in_msb", scan_in, w[N-1]);
    lat = 0;
    while (!rd_valid && lat < N + 6) begin
      @(negedge scan_clk);
      lat++;
    end
    check_val("latency", lat, N + 1);
    check_val("rd_data", rd_data, exp_rd);
    check_val("chain_dout", chain_dout, w);
    check_val("en_edges", en_cnt - en0, N);
    check_val("scan_en_low", scan_en, 0);
    for (int i = 0; i < hold; i++) begin
      wr_valid = poke && (i == 1);
      wr_data  = ~w;
      @(negedge scan_clk);
      check_val("hold_rd_valid", rd_valid, 1);
      check_val("hold_rd_data", rd_data, exp_rd);
      check_val("hold_wr_ready", wr_ready, 0);
      check_val("hold_scan_en", scan_en, 0);
    end
    rd_ready = 1'b1;
    wr_valid = coincide;
    @(negedge scan_clk);
    rd_ready = 1'b0;
    check_val("post_rd_valid", rd_valid, 0);
    check_val("post_rd_data", rd_data, exp_rd);
    check_val("post_wr_ready", wr_ready, 1);
    check_val("post_busy", busy, 0);
    check_val("post_scan_en", scan_en, 0);
    wr_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    int last;
    int n_acc;
    bit acc;
    logic [N-1:0] w;

    exp_chain = rst_din;
    @(negedge scan_clk);
    @(negedge scan_clk);
    check_val("rst_scan_en", scan_en, 0);
    check_val("rst_scan_in", scan_in, 0);
    check_val("rst_rd_valid", rd_valid, 0);
    check_val("rst_rd_data", rd_data, 0);
    check_val("rst_wr_ready", wr_ready, 1);
    check_val("rst_busy", busy, 0);
    scan_rstb = 1'b1;
    @(negedge scan_clk);

    run_op(8'h3C, 0, 0, 0);
    run_op(8'h81, 0, 0, 0);
    run_op(N'($urandom), 5, 1, 0);
    run_op(N'($urandom), 1, 0, 1);
    for (int t = 0; t < 6; t++) begin
      run_op(N'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
    end

    // continuous writes with rd_ready high: one accept per N+3 cycles
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    wr_data  = N'($urandom);
    cyc = 0;
    last = -1;
    n_acc = 0;
    while ((n_acc < 4 || exp_q.size() > 0) && cyc < 200) begin
      acc = 1'b0;
      if (rd_valid) begin
        if (exp_q.size() > 0) check_val("thr_rd_data", rd_data, exp_q.pop_front());
        else check_val("thr_extra_rd", 1, 0);
      end
      if (wr_ready && wr_valid) begin
        if (last >= 0) check_val("thr_gap", cyc - last, N + 3);
        last = cyc;
        exp_q.push_back(exp_chain);
        exp_chain = wr_data;
        n_acc++;
        acc = 1'b1;
      end
      @(negedge scan_clk);
      cyc++;
      if (acc) wr_data = N'($urandom);
      if (n_acc >= 4) wr_valid = 1'b0;
    end
    check_val("thr_timeout", cyc < 200, 1);
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    @(negedge scan_clk);

    // reset in the middle of a shift abandons the operation
    w = N'($urandom);
    wr_valid = 1'b1;
    wr_data  = w;
    @(negedge scan_clk);
    wr_valid = 1'b0;
    repeat (3) @(negedge scan_clk);
    rst_din = N'($urandom);
    scan_rstb = 1'b0;
    #1;
    check_val("mid_rst_scan_en", scan_en, 0);
    check_val("mid_rst_scan_in", scan_in, 0);
    check_val("mid_rst_rd_valid", rd_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_dout", chain_dout, rst_din);
    @(negedge scan_clk);
    scan_rstb = 1'b1;
    exp_chain = rst_din;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge scan_clk);
      check_val("no_stale_rd_valid", rd_valid, 0);
    end
    run_op(8'hFF, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
